// File: rtl/group_uplink_arbiter.sv
// group_uplink_arbiter
//   Shares one router injection port among NUM_REQ network interfaces of a
//   leaf group. Round-robin arbitration, null-header (all-zero routing
//   header) flits are dropped and counted, accepted flits are presented to
//   the router through a single registered output stage (1 flit/cycle).
//
//   Optional build macro: ARB_BURST_EN -- lets one requester keep the grant
//   for up to BURST_LEN consecutive flits while it stays valid.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   req_data    NUM_REQ flits, requester i at [i*DATA_W +: DATA_W]
//   req_valid   per-requester flit valid
//   req_ready   per-requester accept (one-hot or zero, combinational)
//   out_data    registered flit to router
//   out_valid   registered flit valid
//   out_ready   router accepts flit
//   drop_count  saturating count of dropped null-header flits
//   last_grant  index of the most recently accepted requester
module group_uplink_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned HEADER_W  = 6,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                drop_count,
  output logic [2:0]                last_grant
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned GNT_W = 3;
  localparam int unsigned CNT_W = 8;
  // A misconfigured instance never grants rather than misbehaving silently.
  localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) && (BURST_LEN >= 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [GNT_W-1:0]    last_grant_q, last_grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic                found;
  logic [PTR_W-1:0]    win;
  logic [DATA_W-1:0]   win_data;
  int unsigned         scan_idx;
  logic                can_accept;
  logic                xfer;
  logic                hdr_null;

`ifdef ARB_BURST_EN
  localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [BURST_W-1:0]  burst_inc;
`endif

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (32'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[scan_idx]) begin
        found    = 1'b1;
        win      = PTR_W'(scan_idx);
        win_data = req_data[scan_idx*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage frees up either when empty or when drained this cycle.
  assign can_accept = (state_q == ST_EMPTY) | (out_valid_q & out_ready);
  assign xfer       = found & can_accept & ~reset & CFG_OK;
  assign hdr_null   = (win_data[DATA_W-1 -: HEADER_W] == '0);

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win] = 1'b1;
  end

  // Next-state / output-register logic.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    drop_d       = drop_q;
    last_grant_d = last_grant_q;
    rr_ptr_d     = rr_ptr_q;
`ifdef ARB_BURST_EN
    burst_d      = burst_q;
    burst_inc    = ((win == rr_ptr_q) ? burst_q : '0) + BURST_W'(1);
`endif

    case (state_q)
      ST_EMPTY: ;
      ST_FULL: begin
        if (out_ready) begin
          state_d     = ST_EMPTY;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (xfer) begin
      last_grant_d = GNT_W'(win);
`ifdef ARB_BURST_EN
      // Stay on the winner until its burst is used up; a new owner starts fresh.
      if (32'(burst_inc) >= BURST_LEN) begin
        rr_ptr_d = inc_ptr(win);
        burst_d  = '0;
      end else begin
        rr_ptr_d = win;
        burst_d  = burst_inc;
      end
`else
      rr_ptr_d = inc_ptr(win);
`endif
      if (!hdr_null) begin
        out_data_d  = win_data;
        out_valid_d = 1'b1;
        state_d     = ST_FULL;
      end else if (drop_q != '1) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end
`ifdef ARB_BURST_EN
    // Burst owner went idle: hand the pointer on.
    else if (burst_q != '0 && !req_valid[rr_ptr_q]) begin
      rr_ptr_d = inc_ptr(rr_ptr_q);
      burst_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      drop_q       <= '0;
      last_grant_q <= '0;
      rr_ptr_q     <= '0;
`ifdef ARB_BURST_EN
      burst_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      drop_q       <= drop_d;
      last_grant_q <= last_grant_d;
      rr_ptr_q     <= rr_ptr_d;
`ifdef ARB_BURST_EN
      burst_q      <= burst_d;
`endif
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign drop_count = drop_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_group_uplink_arbiter.sv
// Scoreboard bench for group_uplink_arbiter: the driver pushes expected
// grants and router-side flits, a negedge monitor pops and compares.
module tb_group_uplink_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [7:0]                drop_count;
  logic [2:0]                last_grant;

  int errors = 0;
  int checks = 0;
  int          exp_gnt_q[$];
  logic [15:0] exp_out_q[$];
  int          mon_g;
  logic [15:0] mon_d;

  group_uplink_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HEADER_W(6), .BURST_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_count(drop_count), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] d);
    req_data[i*DATA_W +: DATA_W] = d;
    req_valid[i] = 1'b1;
  endtask

  // Monitor: compares grants and router-side handshakes against the queues.
  always @(negedge clk) begin
    if (req_ready != '0) begin
      if (exp_gnt_q.size() == 0) check("unexpected_grant", 32'(req_ready), 32'd0);
      else begin
        mon_g = exp_gnt_q.pop_front();
        check("grant", 32'(req_ready), 32'(1) << mon_g);
      end
    end
    if (out_valid && out_ready) begin
      if (exp_out_q.size() == 0) check("unexpected_flit", 32'(out_data), 32'hDEAD);
      else begin
        mon_d = exp_out_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int burst_seq[9];
`ifdef ARB_BURST_EN
    burst_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
    burst_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif
    reset = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_last_grant", 32'(last_grant), 32'd0);

    // All requesters valid, header 6'b000101: grants rotate 0,1,2,3.
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        check("rr_out_valid", 32'(out_valid), 32'd1);
        check("rr_last_grant", 32'(last_grant), 32'((c - 1) % 4));
      end
      for (int i = 0; i < 4; i++) set_req(i, {6'h05, 2'(i), 8'(c)});
      exp_gnt_q.push_back(c % 4);
      exp_out_q.push_back({6'h05, 2'(c % 4), 8'(c)});
      cyc();
    end
    check("rr_last_grant_end", 32'(last_grant), 32'd3);
    req_valid = '0;
    cyc();

    // Stall: requester 2's flit held while the router is not ready.
    out_ready = 1'b0;
    set_req(2, 16'h7404);
    exp_gnt_q.push_back(2);
    exp_out_q.push_back(16'h7404);
    cyc();
    for (int s = 0; s < 5; s++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'h7404);
      set_req(0, 16'h1400); set_req(1, 16'h1411);
      set_req(2, 16'h1422); set_req(3, 16'h1433);
      cyc();
    end
    out_ready = 1'b1;               // ready reasserts in the same cycle
    exp_gnt_q.push_back(3);
    exp_out_q.push_back(16'h1433);
    cyc();
    req_valid = '0;
    cyc();

    // Null-header flits from requester 1 are accepted and dropped.
    set_req(1, 16'h03FF);
    for (int n = 0; n < 300; n++) begin
      exp_gnt_q.push_back(1);
      cyc();
      if (n == 0) begin
        check("drop_out_valid", 32'(out_valid), 32'd0);
        check("drop_count_1", 32'(drop_count), 32'd1);
      end
    end
    req_valid = '0;
    check("drop_count_sat", 32'(drop_count), 32'd255);
    check("drop_out_valid_end", 32'(out_valid), 32'd0);

    // Wrap: grant 0, then only 3 valid, then all valid goes to 0.
    set_req(0, 16'h1500);
    exp_gnt_q.push_back(0); exp_out_q.push_back(16'h1500);
    cyc();
    check("wrap_last0", 32'(last_grant), 32'd0);
    req_valid = '0;
    set_req(3, 16'h1533);
    exp_gnt_q.push_back(3); exp_out_q.push_back(16'h1533);
    cyc();
    check("wrap_last3", 32'(last_grant), 32'd3);
    set_req(0, 16'h1600); set_req(1, 16'h1611);
    set_req(2, 16'h1622); set_req(3, 16'h1633);
    exp_gnt_q.push_back(0); exp_out_q.push_back(16'h1600);
    cyc();
    check("wrap_next0", 32'(last_grant), 32'd0);
    req_valid = '0;
    cyc();

    // Reset while a flit is held: the flit is discarded.
    out_ready = 1'b0;
    set_req(1, 16'h5001);
    exp_gnt_q.push_back(1);
    cyc();
    req_valid = '0;
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_data", 32'(out_data), 32'h5001);
    reset = 1'b1;
    set_req(0, 16'h1700); set_req(1, 16'h1711);
    set_req(2, 16'h1722); set_req(3, 16'h1733);
    cyc();
    reset = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    check("mid_rst_last", 32'(last_grant), 32'd0);
    out_ready = 1'b1;
    exp_gnt_q.push_back(0); exp_out_q.push_back(16'h1700);
    cyc();
    check("post_rst_last", 32'(last_grant), 32'd0);
    req_valid = '0;
    cyc();

    // Requesters 0 and 1 always valid from a clean reset.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    set_req(0, 16'h1800); set_req(1, 16'h1811);
    for (int n = 0; n < 9; n++) begin
      exp_gnt_q.push_back(burst_seq[n]);
      exp_out_q.push_back(burst_seq[n] == 1 ? 16'h1811 : 16'h1800);
      cyc();
      check("burst_last", 32'(last_grant), 32'(burst_seq[n]));
    end
    req_valid = '0;
    repeat (3) cyc();

    check("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
    check("out_queue_empty", 32'(exp_out_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/group_uplink_arbiter.md
Name: group_uplink_arbiter

Overview:
- Shares one router injection port among NUM_REQ network interfaces in the same leaf group.
- Each requester side is the NI's router-side output: a 16-bit flit whose 6-bit routing header sits in bits [15:10], plus valid/ready.
- The block round-robin arbitrates, drops flits carrying the null header 6'b000000, and presents one registered flit stream to the router.

Parameters:
- NUM_REQ, 4, number of requesting NIs (2..8).
- DATA_W, 16, flit width.
- HEADER_W, 6, routing header width, located at flit bits [DATA_W-1:DATA_W-HEADER_W].
- BURST_LEN, 4, maximum consecutive grants to one requester (used only with ARB_BURST_EN).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- req_data  input  NUM_REQ*DATA_W  flits; requester i occupies bits [i*DATA_W +: DATA_W].
- req_valid  input  NUM_REQ  per-requester flit valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- out_data  output  DATA_W  flit to router, registered.
- out_valid  output  1  out_data valid, registered.
- out_ready  input  1  router accepts the flit.
- drop_count  output  8  saturating count of dropped null-header flits.
- last_grant  output  3  index of the most recently accepted requester.

Behaviour:
- One clock (clk). Reset is synchronous and active-high. While reset is high, req_ready is forced to 0.
- Reset values: out_data=0, out_valid=0, drop_count=0, last_grant=0, rr_ptr=0, burst counter=0, state=EMPTY.
- Output register state machine has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_accept = (state==EMPTY) | (out_valid & out_ready). This gives full throughput of 1 flit/cycle.
- Grant selection (combinational):
  - Scan requesters rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - The first with req_valid=1 wins.
  - req_ready[win]=can_accept; all other req_ready bits are 0.
- Transfer on requester i: req_valid[i] & req_ready[i]. At most one per cycle.
- On a transfer:
  - last_grant<=i.
  - rr_ptr<=(i+1) mod NUM_REQ.
  - Header nonzero: out_data<=flit, out_valid<=1, state->FULL.
  - Header ==0: flit is discarded and drop_count increments, saturating at 255. If the output was drained this cycle, state->EMPTY; otherwise the state is unchanged.
- FULL with out_ready=1 and no transfer: out_valid<=0, state->EMPTY.
- FULL with out_ready=0: out_data and out_valid hold stable. No grant is issued. rr_ptr holds.
- No transfer in a cycle: rr_ptr is unchanged.
- No requester valid: req_ready=0.
- Latency: accepted flit appears on out_valid the cycle after the transfer.
- Ordering: flits from one requester are never reordered. No flit is duplicated.
- Reset mid-operation: a held out_data flit is discarded. Arbitration restarts at requester 0 the cycle after reset deasserts.
- req_ready[i] may depend combinationally on req_valid and out_ready. This is not a loop, because requesters drive valid independently of ready.

Optional Feature:
- Macro: ARB_BURST_EN.
- Defined:
  - After a transfer from requester i, a burst counter increments.
  - rr_ptr stays at i while req_valid[i] remains 1 and the counter is below BURST_LEN.
  - Upon reaching BURST_LEN, or when i deasserts valid, rr_ptr<=(i+1) mod NUM_REQ and the counter is cleared.
  - Dropped flits count toward the burst.
- Undefined: pure single-flit round-robin as above; the burst counter is absent.

Test Plan:
- All 4 requesters valid continuously with headers 6'b000101 and out_ready=1:
  - Grants are 0,1,2,3,0,1… one per cycle.
  - out_valid is continuously 1 from the second cycle.
  - last_grant tracks 0,1,2,3.
- Requester 2 sends 16'h7404 with out_ready=0 for 5 cycles:
  - out_data=16'h7404 is held stable.
  - All req_ready=0.
  - When out_ready rises, req_ready reasserts in the same cycle.
- Requester 1 sends 16'h03FF (null header):
  - req_ready[1]=1, out_valid stays 0, drop_count goes 0->1.
  - 300 such flits -> drop_count=255.
- Only requester 3 valid, after a grant to 0:
  - Scan wraps from rr_ptr=1 and grants 3.
  - Next grant with all valid goes to 0.
- Reset asserted while out_valid=1 (flit 16'h5001 held):
  - Next cycle out_valid=0 and drop_count=0.
  - First post-reset grant, with all valid, goes to requester 0.
- ARB_BURST_EN, BURST_LEN=4, requesters 0 and 1 always valid:
  - Grant sequence is 0,0,0,0,1,1,1,1,0.
  - Without the macro: 0,1,0,1.
